i2c_reg_write_master: RTL

- Downstream of the timed trigger FSM in the i2c_pipeline test project.
- On an accepted start, performs one complete I2C register write over an open-drain bus: START, 7-bit device address + W, register address byte, data byte, STOP.
- Reports completion and any NACK back to the sequencing logic.
- No clock stretching, no reads, single master.

---
 rtl/i2c_reg_write_master.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/i2c_reg_write_master.sv
// I2C register-write master: START, {dev_addr,W}, reg_addr, wr_data, STOP on open-drain lines.
// Each bit slot is four phases of CLK_DIV clocks; SCL is released during phases 1 and 2.
module i2c_reg_write_master #(
  parameter int CLK_DIV = 4,
  parameter int DIV_W   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wr_data,
  input  logic       sda_i,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_error
);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ACK_A, REG, ACK_R, DATA, ACK_D, STOP
  } state_t;

  localparam logic [DIV_W-1:0] QMAX = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] QONE = DIV_W'(1);

  state_t           state, state_nxt;
  logic [DIV_W-1:0] qcnt;
  logic [1:0]       phase;
  logic [2:0]       bit_cnt;
  logic [7:0]       addr_byte, reg_byte, data_byte, cur_byte;
  logic             q_end, slot_end, accept, in_byte, in_ack, ack_sample, cur_bit;

  assign q_end      = (qcnt == QMAX);
  assign slot_end   = q_end && (phase == 2'd3);
  assign accept     = (state == IDLE) && start;
  assign in_byte    = (state == ADDR) || (state == REG) || (state == DATA);
  assign in_ack     = (state == ACK_A) || (state == ACK_R) || (state == ACK_D);
  // ACK is read on the last cycle SCL has been high for a full quarter
  assign ack_sample = in_ack && (phase == 2'd1) && q_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      qcnt      <= '0;
      phase     <= '0;
      bit_cnt   <= '0;
      ack_error <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        qcnt    <= '0;
        phase   <= '0;
        bit_cnt <= '0;
      end else if (q_end) begin
        qcnt  <= '0;
        phase <= phase + 2'd1;
        if (slot_end)
          bit_cnt <= (in_byte && bit_cnt != 3'd7) ? bit_cnt + 3'd1 : 3'd0;
      end else begin
        qcnt <= qcnt + QONE;
      end
      if (accept)
        ack_error <= 1'b0;
      else if (ack_sample && sda_i)
        ack_error <= 1'b1;
    end
  end

  // Transaction bytes are captured once so the inputs may change after accept
  always_ff @(posedge clk) begin
    if (accept && !reset) begin
      addr_byte <= {dev_addr, 1'b0};
      reg_byte  <= reg_addr;
      data_byte <= wr_data;
    end
  end

  always_comb begin
    cur_byte = addr_byte;
    case (state)
      REG:     cur_byte = reg_byte;
      DATA:    cur_byte = data_byte;
      default: cur_byte = addr_byte;
    endcase
    cur_bit = cur_byte[~bit_cnt];
  end

  always_comb begin
    state_nxt = state;
    scl_oe    = 1'b0;
    sda_oe    = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) state_nxt = START;
      end
      START: begin
        sda_oe = phase[1];
        scl_oe = (phase == 2'd3);
        if (slot_end) state_nxt = ADDR;
      end
      ADDR, REG, DATA: begin
        scl_oe = (phase == 2'd0) || (phase == 2'd3);
        sda_oe = ~cur_bit;
        if (slot_end && bit_cnt == 3'd7) begin
          case (state)
            ADDR:    state_nxt = ACK_A;
            REG:     state_nxt = ACK_R;
            default: state_nxt = ACK_D;
          endcase
        end
      end
      ACK_A: begin
        scl_oe = (phase == 2'd0) || (phase == 2'd3);
        if (slot_end) state_nxt = ack_error ? STOP : REG;
      end
      ACK_R: begin
        scl_oe = (phase == 2'd0) || (phase == 2'd3);
        if (slot_end) state_nxt = ack_error ? STOP : DATA;
      end
      ACK_D: begin
        scl_oe = (phase == 2'd0) || (phase == 2'd3);
        if (slot_end) state_nxt = STOP;
      end
      STOP: begin
        scl_oe = (phase == 2'd0);
        sda_oe = (phase == 2'd0) || (phase == 2'd1);
        if (slot_end) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
